// File: rtl/ripple_count_tracker.sv
`default_nettype none
// ============================================================================
// ripple_count_tracker : synchronise, de-glitch and extend a ripple count
// Revision 1.0
// ============================================================================
module ripple_count_tracker #(
  parameter int WIDTH         = 4,
  parameter int EXT_WIDTH     = 12,
  parameter int STABLE_CYCLES = 2
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic [WIDTH-1:0]     q_in,
  input  logic                 enable,
  input  logic [EXT_WIDTH-1:0] match_value,
  output logic [EXT_WIDTH-1:0] count_out,
  output logic                 count_valid,
  input  logic                 count_ready,
  output logic                 wrap_pulse,
  output logic                 match,
  output logic                 overrun,
  output logic                 error
);

  localparam logic [2:0] STAB_TGT = 3'(STABLE_CYCLES);
  localparam int         PAD      = EXT_WIDTH - WIDTH;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  state_t               state;
  state_t               state_next;

  logic [WIDTH-1:0]     r_sync1;
  logic [WIDTH-1:0]     r_sync2;
  logic                 r_primed;
  logic [2:0]           r_stab_cnt;
  logic [WIDTH-1:0]     r_baseline;
  logic [EXT_WIDTH-1:0] r_ext_count;

  logic                 r_upd_evt;
  logic                 r_wrap_evt;
  logic                 r_match_evt;
  logic                 r_err_evt;

  logic [2:0]           w_stab_next;
  logic                 w_new_run;
  logic                 w_hit;
  logic                 w_load_base;
  logic                 w_track_acc;
  logic                 w_do_add;
  logic                 w_wrap;
  logic                 w_big;
  logic [WIDTH-1:0]     w_delta;
  logic [EXT_WIDTH-1:0] w_ext_next;

  // r_primed masks the reset value of r_sync1 so it never starts a run.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_primed   <= 1'b0;
      r_stab_cnt <= 3'd0;
    end else begin
      r_sync1    <= q_in;
      r_sync2    <= r_sync1;
      r_primed   <= 1'b1;
      r_stab_cnt <= w_stab_next;
    end
  end

  // r_stab_cnt is the run length of r_sync2; r_sync1 is the value it takes next.
  always_comb begin
    w_new_run   = (r_stab_cnt == 3'd0) || (r_sync1 != r_sync2);
    w_stab_next = r_stab_cnt;
    if (!r_primed) begin
      w_stab_next = 3'd0;
    end else if (w_new_run) begin
      w_stab_next = 3'd1;
    end else if (r_stab_cnt >= STAB_TGT) begin
      w_stab_next = STAB_TGT;
    end else begin
      w_stab_next = r_stab_cnt + 3'd1;
    end
    w_hit = r_primed && (w_stab_next == STAB_TGT) &&
            (w_new_run || (r_stab_cnt < STAB_TGT));
  end

  always_comb begin
    w_delta    = r_sync1 - r_baseline;
    w_wrap     = (r_sync1 < r_baseline);
    w_big      = w_delta[WIDTH-1] && (w_delta[WIDTH-2:0] != '0);
    w_ext_next = r_ext_count + {{PAD{1'b0}}, w_delta};
    w_do_add   = w_track_acc && enable;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= ST_INIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    w_load_base = 1'b0;
    w_track_acc = 1'b0;
    case (state)
      ST_INIT: begin
        if (w_hit) begin
          w_load_base = 1'b1;
          state_next  = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (w_hit && (r_sync1 != r_baseline)) begin
          w_track_acc = 1'b1;
        end
      end
      default: state_next = ST_INIT;
    endcase
  end

  // Acceptance stage: baseline/extended count update and event capture.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_baseline  <= '0;
      r_ext_count <= '0;
      r_upd_evt   <= 1'b0;
      r_wrap_evt  <= 1'b0;
      r_match_evt <= 1'b0;
      r_err_evt   <= 1'b0;
    end else begin
      if (w_load_base || w_track_acc) begin
        r_baseline <= r_sync1;
      end
      if (w_do_add) begin
        r_ext_count <= w_ext_next;
      end
      r_upd_evt   <= w_do_add;
      r_wrap_evt  <= w_track_acc && w_wrap;
      r_err_evt   <= w_track_acc && w_big;
      r_match_evt <= w_do_add && (r_ext_count < match_value) &&
                     (w_ext_next >= match_value);
    end
  end

  // Output stage: snapshot register with valid/ready handshake.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      count_out   <= '0;
      count_valid <= 1'b0;
      wrap_pulse  <= 1'b0;
      match       <= 1'b0;
      overrun     <= 1'b0;
      error       <= 1'b0;
    end else begin
      wrap_pulse <= r_wrap_evt;
      match      <= r_match_evt;
      if (r_err_evt) begin
        error <= 1'b1;
      end
      if (r_upd_evt) begin
        count_out   <= r_ext_count;
        count_valid <= 1'b1;
        if (count_valid && !count_ready) begin
          overrun <= 1'b1;
        end
      end else if (count_valid && count_ready) begin
        count_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ripple_count_tracker.sv
`default_nettype none
// ============================================================================
// tb_ripple_count_tracker : directed stimulus against a sample-history model
// Revision 1.0
// ============================================================================
module tb_ripple_count_tracker;

  localparam int W    = 4;
  localparam int EW   = 12;
  localparam int S    = 2;
  localparam int MOD  = 1 << W;
  localparam int HALF = 1 << (W - 1);
  localparam int EMOD = 1 << EW;

  logic          clock = 1'b0;
  logic          clear = 1'b1;
  logic [W-1:0]  q_in = 4'd5;
  logic          enable = 1'b1;
  logic [EW-1:0] match_value = 12'hFFF;
  logic [EW-1:0] count_out;
  logic          count_valid;
  logic          count_ready = 1'b1;
  logic          wrap_pulse;
  logic          match;
  logic          overrun;
  logic          error;

  ripple_count_tracker #(
    .WIDTH(W),
    .EXT_WIDTH(EW),
    .STABLE_CYCLES(S)
  ) dut (
    .clock(clock),
    .clear(clear),
    .q_in(q_in),
    .enable(enable),
    .match_value(match_value),
    .count_out(count_out),
    .count_valid(count_valid),
    .count_ready(count_ready),
    .wrap_pulse(wrap_pulse),
    .match(match),
    .overrun(overrun),
    .error(error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: acceptance = S equal samples closing a fresh run in the sample history.
  int  hist[$];
  bit  m_init;
  int  m_base, m_ext, m_n, m_v, m_d, m_old;
  bit  m_hit;
  bit  p_upd, p_wrap, p_match, p_err;
  int  e_out;
  bit  e_valid, e_wrap, e_match, e_ovr, e_err;
  int  wraps_seen = 0;
  int  matches_seen = 0;
  int  valid_seen = 0;

  always begin
    @(posedge clock);
    if (clear) begin
      hist.delete();
      m_init = 1'b1; m_base = 0; m_ext = 0;
      p_upd = 0; p_wrap = 0; p_match = 0; p_err = 0;
      e_out = 0; e_valid = 0; e_wrap = 0; e_match = 0; e_ovr = 0; e_err = 0;
    end else begin
      e_wrap  = p_wrap;
      e_match = p_match;
      if (p_err) e_err = 1'b1;
      if (p_upd) begin
        if (e_valid && !count_ready) e_ovr = 1'b1;
        e_out   = m_ext;
        e_valid = 1'b1;
      end else if (e_valid && count_ready) begin
        e_valid = 1'b0;
      end
      p_upd = 0; p_wrap = 0; p_match = 0; p_err = 0;

      m_n   = hist.size();
      m_hit = 1'b0;
      if (m_n >= S) begin
        m_v   = hist[m_n-1];
        m_hit = 1'b1;
        for (int i = m_n - S; i < m_n; i++) if (hist[i] != m_v) m_hit = 1'b0;
        if (m_n > S && hist[m_n-S-1] == m_v) m_hit = 1'b0;
      end
      if (m_hit) begin
        if (m_init) begin
          m_base = m_v;
          m_init = 1'b0;
        end else if (m_v != m_base) begin
          m_d    = (m_v - m_base + MOD) % MOD;
          p_wrap = (m_v < m_base);
          p_err  = (m_d > HALF);
          if (enable) begin
            m_old   = m_ext;
            m_ext   = (m_ext + m_d) % EMOD;
            p_upd   = 1'b1;
            p_match = (m_old < int'(match_value)) && (m_ext >= int'(match_value));
          end
          m_base = m_v;
        end
      end
      hist.push_back(int'(q_in));
    end
    #1;
    chk("count_out",   int'(count_out),   e_out);
    chk("count_valid", int'(count_valid), int'(e_valid));
    chk("wrap_pulse",  int'(wrap_pulse),  int'(e_wrap));
    chk("match",       int'(match),       int'(e_match));
    chk("overrun",     int'(overrun),     int'(e_ovr));
    chk("error",       int'(error),       int'(e_err));
    wraps_seen   += int'(wrap_pulse);
    matches_seen += int'(match);
    valid_seen   += int'(count_valid);
  end

  task automatic step(input int v, input int n);
    q_in = W'(v);
    repeat (n) @(negedge clock);
  endtask

  int v0, w0, m0;

  initial begin
    repeat (3) @(negedge clock);
    clear = 1'b0;
    repeat (10) @(negedge clock);
    chk("init_valid", int'(count_valid), 0);
    chk("init_out",   int'(count_out),   0);

    v0 = valid_seen;
    step(6, 10);
    step(7, 10);
    chk("step_out",          int'(count_out),   2);
    chk("step_valid_cycles", valid_seen - v0,   2);
    chk("step_valid_low",    int'(count_valid), 0);

    w0 = wraps_seen;
    step(14, 10); step(15, 10); step(0, 10); step(1, 10);
    chk("wrap_once", wraps_seen - w0,  1);
    chk("wrap_out",  int'(count_out), 12);

    step(3, 10); step(7, 1); step(4, 10);
    chk("glitch_out", int'(count_out), 15);
    chk("glitch_err", int'(error),      0);

    count_ready = 1'b0;
    step(5, 10); step(6, 10);
    chk("ovr_out",   int'(count_out),   17);
    chk("ovr_flag",  int'(overrun),      1);
    chk("ovr_valid", int'(count_valid),  1);
    count_ready = 1'b1;
    repeat (3) @(negedge clock);
    chk("xfer_valid",  int'(count_valid), 0);
    chk("xfer_sticky", int'(overrun),     1);

    clear = 1'b1;
    match_value = 12'd3;
    repeat (2) @(negedge clock);
    chk("clr_out", int'(count_out), 0);
    chk("clr_ovr", int'(overrun),   0);
    clear = 1'b0;
    repeat (10) @(negedge clock);

    m0 = matches_seen;
    step(7, 10);
    enable = 1'b0;
    step(8, 10);
    enable = 1'b1;
    step(9, 10); step(10, 10); step(11, 10);
    chk("match_once", matches_seen - m0, 1);
    chk("match_out",  int'(count_out),   4);

    step(2, 10);
    chk("jump_pre_err", int'(error),      0);
    chk("jump_pre_out", int'(count_out), 11);
    step(12, 10);
    chk("jump_err", int'(error),      1);
    chk("jump_out", int'(count_out), 21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
